// File: rtl/ram_lsu.sv
// Load/store initiator between the RV32 memory stage and a word-wide data RAM.
// Sub-word stores use read-modify-write; bad requests complete at once with err_o.
module ram_lsu #(
    parameter logic [31:0] RAM_BASE  = 32'h2000_0000,
    parameter logic [31:0] RAM_BYTES = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    res = {{24{b[7]}}, b};
            F3_H:    res = {{16{h[15]}}, h};
            F3_BU:   res = {24'h00_0000, b};
            F3_HU:   res = {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [15:0] data);
        logic [31:0] res;
        res = word;
        case (f3)
            F3_B: begin
                case (lane)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    2'd3:    res[31:24] = data[7:0];
                    default: res = word;
                endcase
            end
            F3_H: begin
                if (lane[1]) begin
                    res[31:16] = data;
                end else begin
                    res[15:0] = data;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    state_t      state_r, state_nxt_s;
    logic        store_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [15:0] wdata_r;
    logic        busy_r, done_r, err_r, mem_we_r;
    logic [31:0] rdata_r, mem_addr_r, mem_wdata_r;
    logic        accept_s, misaligned_s, out_of_range_s, illegal_s, req_err_s, err_nxt_s;
    logic [31:0] offset_s, mem_addr_nxt_s, mem_wdata_nxt_s;

    assign accept_s = (state_r == ST_IDLE) && req_i;

    // Request legality, judged on the raw inputs so the decision is ready at accept
    always_comb begin
        offset_s       = addr_i - RAM_BASE;
        out_of_range_s = (offset_s >= RAM_BYTES);
        case (funct3_i)
            F3_H, F3_HU: misaligned_s = addr_i[0];
            F3_W:        misaligned_s = (addr_i[1:0] != 2'b00);
            default:     misaligned_s = 1'b0;
        endcase
        case (funct3_i)
            F3_B, F3_H, F3_W: illegal_s = 1'b0;
            F3_BU, F3_HU:     illegal_s = store_i;
            default:          illegal_s = 1'b1;
        endcase
        req_err_s = misaligned_s | out_of_range_s | illegal_s;
    end

    // Next state plus the bus values the next state will present
    always_comb begin
        state_nxt_s     = state_r;
        err_nxt_s       = 1'b0;
        mem_addr_nxt_s  = 32'h0000_0000;
        mem_wdata_nxt_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (!req_i) begin
                    state_nxt_s = ST_IDLE;
                end else if (req_err_s) begin
                    state_nxt_s = ST_RESP;
                    err_nxt_s   = 1'b1;
                end else if (store_i && (funct3_i == F3_W)) begin
                    state_nxt_s     = ST_WR;
                    mem_addr_nxt_s  = {addr_i[31:2], 2'b00};
                    mem_wdata_nxt_s = wdata_i;
                end else begin
                    state_nxt_s    = ST_RD;
                    mem_addr_nxt_s = {addr_i[31:2], 2'b00};
                end
            end
            ST_RD: begin
                if (store_r) begin
                    state_nxt_s     = ST_WR;
                    mem_addr_nxt_s  = {addr_r[31:2], 2'b00};
                    mem_wdata_nxt_s = store_merge(mem_rdata_i, funct3_r, addr_r[1:0], wdata_r);
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_WR:   state_nxt_s = ST_RESP;
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and registered control/bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_RESP);
            err_r       <= err_nxt_s;
            mem_we_r    <= (state_nxt_s == ST_WR);
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
        end
    end

    // Request capture; only the low halfword of store data is needed after accept
    always_ff @(posedge clk) begin
        if (rst) begin
            store_r  <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= 32'h0000_0000;
            wdata_r  <= 16'h0000;
        end else if (accept_s) begin
            store_r  <= store_i;
            funct3_r <= funct3_i;
            addr_r   <= addr_i;
            wdata_r  <= wdata_i[15:0];
        end
    end

    // Load result: cleared on accept, filled from the RAM word at the end of RD
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else if ((state_r == ST_RD) && !store_r) begin
            rdata_r <= load_extend(mem_rdata_i, funct3_r, addr_r[1:0]);
        end else if (accept_s) begin
            rdata_r <= 32'h0000_0000;
        end
    end

    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign err_o       = err_r;
    assign rdata_o     = rdata_r;
    assign mem_we_o    = mem_we_r & ~rst;
    assign mem_addr_o  = mem_addr_r;
    assign mem_wdata_o = mem_wdata_r;

endmodule

// File: tb/tb_ram_lsu.sv
// Bench for ram_lsu: small RAM, transaction-level reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_ram_lsu;

    logic        clk = 1'b0;
    logic        rst, req_i, store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        busy_o, done_o, err_o, mem_we_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

    logic [31:0] ram [0:15];

    int n_vec = 0;
    int n_err = 0;
    int n_we_seen = 0;
    int n_done_seen = 0;

    // reference model state (one transaction at a time)
    logic        m_active, m_err, m_load;
    int          m_cyc, m_lat, m_we_cyc;
    logic [31:0] m_addr, m_wdata, m_ldval, exp_rdata;
    logic [31:0] mdl_mem [0:15];

    ram_lsu dut (
        .clk(clk), .rst(rst), .req_i(req_i), .store_i(store_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rdata_o(rdata_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    assign mem_rdata_i = ram[mem_addr_o[5:2]];

    always @(posedge clk) begin
        if (mem_we_o) ram[mem_addr_o[5:2]] <= mem_wdata_o;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Work out what a request on the current inputs must do, from the rules alone
    task automatic model_accept();
        logic [31:0] a, w, v, mask;
        int sz, sh;
        logic legal;
        a = addr_i;
        case (funct3_i)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            default:        sz = 4;
        endcase
        legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                (!store_i && ((funct3_i == 3'b100) || (funct3_i == 3'b101)));
        m_err = !legal || ((a % 32'(sz)) != 32'd0) ||
                (a < 32'h2000_0000) || (a >= 32'h3000_0000);
        m_addr   = {a[31:2], 2'b00};
        sh       = 8 * int'(a[1:0]);
        w        = mdl_mem[a[5:2]];
        m_load   = !store_i;
        m_lat    = 1;
        m_we_cyc = 0;
        m_ldval  = 32'd0;
        m_wdata  = 32'd0;
        if (!m_err) begin
            if (!store_i) begin
                m_lat = 2;
                v = w >> sh;
                if (sz == 1) begin
                    v = (funct3_i[2] || !v[7]) ? (v & 32'h0000_00FF) : ((v & 32'h0000_00FF) | 32'hFFFF_FF00);
                end else if (sz == 2) begin
                    v = (funct3_i[2] || !v[15]) ? (v & 32'h0000_FFFF) : ((v & 32'h0000_FFFF) | 32'hFFFF_0000);
                end
                m_ldval = v;
            end else begin
                mask     = (sz == 4) ? 32'hFFFF_FFFF : (((sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF) << sh);
                m_wdata  = (w & ~mask) | ((wdata_i << sh) & mask);
                m_lat    = (sz == 4) ? 2 : 3;
                m_we_cyc = m_lat - 1;
            end
        end
    endtask

    // Compare process: check every cycle at the falling edge, then advance the model
    initial begin
        logic e_done, e_bus, e_we;
        m_active = 1'b0; m_err = 1'b0; m_load = 1'b0;
        m_cyc = 0; m_lat = 0; m_we_cyc = 0;
        m_addr = 32'd0; m_wdata = 32'd0; m_ldval = 32'd0; exp_rdata = 32'd0;
        for (int i = 0; i < 16; i++) mdl_mem[i] = 32'd0;
        forever begin
            @(negedge clk);
            e_done = m_active && (m_cyc == m_lat);
            e_bus  = m_active && !m_err && (m_cyc < m_lat);
            e_we   = m_active && (m_cyc == m_we_cyc);
            chk("busy", {31'd0, busy_o}, {31'd0, m_active});
            chk("done", {31'd0, done_o}, {31'd0, e_done});
            chk("err", {31'd0, err_o}, {31'd0, e_done && m_err});
            chk("rdata", rdata_o, exp_rdata);
            chk("mem_we", {31'd0, mem_we_o}, {31'd0, e_we && !rst});
            chk("mem_addr", mem_addr_o, e_bus ? m_addr : 32'd0);
            if (!e_bus) chk("mem_wdata_idle", mem_wdata_o, 32'd0);
            else if (e_we) chk("mem_wdata", mem_wdata_o, m_wdata);
            if (mem_we_o) n_we_seen++;
            if (done_o) n_done_seen++;
            if (e_we && !rst) mdl_mem[m_addr[5:2]] = m_wdata;
            if (rst) begin
                m_active  = 1'b0;
                exp_rdata = 32'd0;
            end else if (m_active) begin
                m_cyc++;
                if (m_cyc > m_lat) m_active = 1'b0;
                else if ((m_cyc == m_lat) && m_load && !m_err) exp_rdata = m_ldval;
            end else if (req_i) begin
                model_accept();
                m_active  = 1'b1;
                m_cyc     = 1;
                exp_rdata = 32'd0;
            end
        end
    end

    task automatic run_op(input string name, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int exp_cyc, input logic exp_err, input int exp_we,
                          input logic chk_rd, input logic [31:0] exp_rd);
        int we0, got;
        logic [31:0] rd;
        logic er;
        @(posedge clk); #1;
        req_i = 1'b1; store_i = st; funct3_i = f3; addr_i = a; wdata_i = wd;
        we0 = n_we_seen;
        @(posedge clk); #1;
        req_i = 1'b0;
        got = 0; rd = 32'd0; er = 1'b0;
        for (int k = 1; (k <= 8) && (got == 0); k++) begin
            @(negedge clk);
            if (done_o) begin
                got = k; rd = rdata_o; er = err_o;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk({name, "_done_cycle"}, 32'(got), 32'(exp_cyc));
        chk({name, "_err"}, {31'd0, er}, {31'd0, exp_err});
        chk({name, "_we_pulses"}, 32'(n_we_seen - we0), 32'(exp_we));
        if (chk_rd) chk({name, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        int d0, w0, dones, first;
        rst = 1'b1; req_i = 1'b0; store_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'd0; wdata_i = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy_o}, 32'd0);
        chk("reset_done", {31'd0, done_o}, 32'd0);
        chk("reset_rdata", rdata_o, 32'd0);
        chk("reset_mem_addr", mem_addr_o, 32'd0);

        run_op("sw",  1'b1, 3'b010, 32'h2000_0000, 32'h1122_3344, 2, 1'b0, 1, 1'b0, 32'd0);
        run_op("lw",  1'b0, 3'b010, 32'h2000_0000, 32'd0,         2, 1'b0, 0, 1'b1, 32'h1122_3344);
        run_op("sb",  1'b1, 3'b000, 32'h2000_0003, 32'h0000_00A5, 3, 1'b0, 1, 1'b0, 32'd0);
        chk("ram_after_sb", ram[0], 32'hA522_3344);
        run_op("lb",  1'b0, 3'b000, 32'h2000_0003, 32'd0, 2, 1'b0, 0, 1'b1, 32'hFFFF_FFA5);
        run_op("lbu", 1'b0, 3'b100, 32'h2000_0003, 32'd0, 2, 1'b0, 0, 1'b1, 32'h0000_00A5);
        run_op("lh",  1'b0, 3'b001, 32'h2000_0002, 32'd0, 2, 1'b0, 0, 1'b1, 32'hFFFF_A522);
        run_op("lhu", 1'b0, 3'b101, 32'h2000_0002, 32'd0, 2, 1'b0, 0, 1'b1, 32'h0000_A522);
        run_op("lh_misal", 1'b0, 3'b001, 32'h2000_0001, 32'd0,      1, 1'b1, 0, 1'b1, 32'd0);
        run_op("sw_range", 1'b1, 3'b010, 32'h1FFF_FFFC, 32'hDEAD_0001, 1, 1'b1, 0, 1'b0, 32'd0);
        run_op("ld_f3_011", 1'b0, 3'b011, 32'h2000_0000, 32'd0,     1, 1'b1, 0, 1'b0, 32'd0);
        run_op("st_bu",   1'b1, 3'b100, 32'h2000_0000, 32'h0000_0077, 1, 1'b1, 0, 1'b0, 32'd0);
        chk("ram_after_errors", ram[0], 32'hA522_3344);
        run_op("sw_top",  1'b1, 3'b010, 32'h2FFF_FFFC, 32'hCAFE_BABE, 2, 1'b0, 1, 1'b0, 32'd0);
        run_op("lhu_top", 1'b0, 3'b101, 32'h2FFF_FFFE, 32'd0, 2, 1'b0, 0, 1'b1, 32'h0000_CAFE);
        run_op("lw_past", 1'b0, 3'b010, 32'h3000_0000, 32'd0, 1, 1'b1, 0, 1'b0, 32'd0);
        run_op("sh_hi",   1'b1, 3'b001, 32'h2000_0002, 32'h0000_1234, 3, 1'b0, 1, 1'b0, 32'd0);
        run_op("lw_sh",   1'b0, 3'b010, 32'h2000_0000, 32'd0, 2, 1'b0, 0, 1'b1, 32'h1234_3344);

        // SH aborted by reset during its write cycle
        d0 = n_done_seen; w0 = n_we_seen;
        @(posedge clk); #1;
        req_i = 1'b1; store_i = 1'b1; funct3_i = 3'b001; addr_i = 32'h2000_0000; wdata_i = 32'h0000_BEEF;
        @(posedge clk); #1;
        req_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_dones", 32'(n_done_seen - d0), 32'd0);
        chk("abort_we", 32'(n_we_seen - w0), 32'd0);
        run_op("lw_abort", 1'b0, 3'b010, 32'h2000_0000, 32'd0, 2, 1'b0, 0, 1'b1, 32'h1234_3344);

        // req_i held through a whole load and into the following idle cycle
        @(posedge clk); #1;
        req_i = 1'b1; store_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h2000_0000;
        dones = 0; first = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 4) req_i = 1'b0;
            @(negedge clk);
            if (done_o) begin
                dones++;
                if (first == 0) first = k;
            end
        end
        chk("held_dones", 32'(dones), 32'd2);
        chk("held_first_done", 32'(first), 32'd2);
        chk("held_rdata", rdata_o, 32'h1234_3344);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
